// File: rtl/ratio_fifo_if.sv
// Bus bundle for ratio_fifo: wide write side, narrow show-ahead read side, occupancy and flags.
interface ratio_fifo_if #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RATIO      = 2
);
  logic                        wr;
  logic                        rd;
  logic [RATIO*DATA_WIDTH-1:0] w_data;
  logic [DATA_WIDTH-1:0]       r_data;
  logic                        full;
  logic                        empty;
  logic                        almost_full;
  logic                        almost_empty;
  logic [ADDR_WIDTH:0]         count;

  modport master (
    output wr, rd, w_data,
    input  r_data, full, empty, almost_full, almost_empty, count
  );

  modport slave (
    input  wr, rd, w_data,
    output r_data, full, empty, almost_full, almost_empty, count
  );
endinterface

// File: rtl/ratio_fifo.sv
// Asymmetric FIFO: RATIO narrow words per write, one narrow word per read, show-ahead output.
// Optional sticky overflow/underflow flags (ports ovf/udf) when RATIO_FIFO_ERR_EN is defined.
module ratio_fifo #(
  parameter int unsigned ADDR_WIDTH      = 3,
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned RATIO           = 2,
  parameter int unsigned ALMOST_FULL_TH  = 6,
  parameter int unsigned ALMOST_EMPTY_TH = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  ratio_fifo_if.slave bus
`ifdef RATIO_FIFO_ERR_EN
  ,
  output logic       ovf,
  output logic       udf
`endif
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam int unsigned CntW  = ADDR_WIDTH + 1;

  localparam logic [CntW-1:0]       FullLim  = CntW'(Depth - RATIO);
  localparam logic [CntW-1:0]       AfTh     = CntW'(ALMOST_FULL_TH);
  localparam logic [CntW-1:0]       AeTh     = CntW'(ALMOST_EMPTY_TH);
  localparam logic [CntW-1:0]       RatioCnt = CntW'(RATIO);
  localparam logic [ADDR_WIDTH-1:0] RatioPtr = ADDR_WIDTH'(RATIO);

  if (RATIO == 0 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio_pow2
    $error("ratio_fifo: RATIO must be a power of 2");
  end
  if (RATIO > Depth) begin : g_bad_ratio_depth
    $error("ratio_fifo: RATIO exceeds DEPTH");
  end
  if (ALMOST_FULL_TH > Depth || ALMOST_EMPTY_TH > Depth) begin : g_bad_th
    $error("ratio_fifo: threshold exceeds DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
  logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  full, empty, wr_en, rd_en;

  // All flags derive from the registered count so they are glitch-free relative to state.
  always_comb begin
    full    = count_q > FullLim;
    empty   = count_q == '0;
    wr_en   = bus.wr & ~full;
    rd_en   = bus.rd & ~empty;
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    count_d = count_q;
    if (wr_en) begin
      w_ptr_d = w_ptr_q + RatioPtr;
      count_d = count_d + RatioCnt;
    end
    if (rd_en) begin
      r_ptr_d = r_ptr_q + 1'b1;
      count_d = count_d - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      count_q <= '0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      count_q <= count_d;
    end
  end

  // Storage is intentionally not reset; w_ptr stays RATIO-aligned so slices never straddle a wrap.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned k = 0; k < RATIO; k++) begin
        mem_q[w_ptr_q + ADDR_WIDTH'(k)] <= bus.w_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    bus.r_data       = empty ? '0 : mem_q[r_ptr_q];
    bus.full         = full;
    bus.empty        = empty;
    bus.almost_full  = count_q >= AfTh;
    bus.almost_empty = count_q <= AeTh;
    bus.count        = count_q;
  end

`ifdef RATIO_FIFO_ERR_EN
  logic ovf_q, ovf_d, udf_q, udf_d;

  always_comb begin
    ovf_d = ovf_q | (bus.wr & full);
    udf_d = udf_q | (bus.rd & empty);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
`endif

endmodule

// File: tb/tb_ratio_fifo.sv
// Directed bench for ratio_fifo: RATIO=2 and RATIO=4 instances plus a modelled wrap-around run.
module tb_ratio_fifo;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   n_vec = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  ratio_fifo_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .RATIO(2)) b2 ();
  ratio_fifo_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .RATIO(4)) b4 ();

`ifdef RATIO_FIFO_ERR_EN
  logic ovf2, udf2, ovf4, udf4;
`endif

  ratio_fifo #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .RATIO(2)) u_dut2 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (b2)
`ifdef RATIO_FIFO_ERR_EN
    ,
    .ovf     (ovf2),
    .udf     (udf2)
`endif
  );

  ratio_fifo #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .RATIO(4)) u_dut4 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (b4)
`ifdef RATIO_FIFO_ERR_EN
    ,
    .ovf     (ovf4),
    .udf     (udf4)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wr2(input logic [15:0] d);
    b2.wr = 1'b1; b2.w_data = d;
    cycle();
    b2.wr = 1'b0;
  endtask

  task automatic rd2();
    b2.rd = 1'b1;
    cycle();
    b2.rd = 1'b0;
  endtask

  task automatic wr4(input logic [31:0] d);
    b4.wr = 1'b1; b4.w_data = d;
    cycle();
    b4.wr = 1'b0;
  endtask

  task automatic rd4();
    b4.rd = 1'b1;
    cycle();
    b4.rd = 1'b0;
  endtask

  logic [7:0] q[$];

  initial begin
    b2.wr = 1'b0; b2.rd = 1'b0; b2.w_data = '0;
    b4.wr = 1'b0; b4.rd = 1'b0; b4.w_data = '0;

    // Reset state
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_empty", b2.empty, 1);
    check_eq("rst_full", b2.full, 0);
    check_eq("rst_count", b2.count, 0);
    check_eq("rst_rdata", b2.r_data, 8'h00);
    check_eq("rst_ae", b2.almost_empty, 1);
    check_eq("rst_af", b2.almost_full, 0);
    @(negedge clk) reset_n = 1'b1;

    // Single write then drain
    wr2(16'hBBAA);
    check_eq("w1_count", b2.count, 2);
    check_eq("w1_rdata", b2.r_data, 8'hAA);
    check_eq("w1_empty", b2.empty, 0);
    check_eq("w1_ae", b2.almost_empty, 0);
    rd2();
    check_eq("r1_rdata", b2.r_data, 8'hBB);
    check_eq("r1_count", b2.count, 1);
    check_eq("r1_ae", b2.almost_empty, 1);
    rd2();
    check_eq("r2_empty", b2.empty, 1);
    check_eq("r2_rdata", b2.r_data, 8'h00);

    // Fill to full, rejected write, read back below full
    wr2(16'h1100);
    wr2(16'h3322);
    wr2(16'h5544);
    rd2();
    check_eq("f_count5", b2.count, 5);
    check_eq("f_head11", b2.r_data, 8'h11);
    wr2(16'h7766);
    check_eq("f_count7", b2.count, 7);
    check_eq("f_full", b2.full, 1);
    check_eq("f_af", b2.almost_full, 1);
    wr2(16'h9988);
    check_eq("f_rej_count", b2.count, 7);
    check_eq("f_rej_head", b2.r_data, 8'h11);
`ifdef RATIO_FIFO_ERR_EN
    check_eq("f_ovf", ovf2, 1);
`endif
    rd2();
    check_eq("f_count6", b2.count, 6);
    check_eq("f_notfull", b2.full, 0);
    check_eq("f_head22", b2.r_data, 8'h22);
    check_eq("f_af6", b2.almost_full, 1);

    // Async reset between edges at count 6
    @(negedge clk) reset_n = 1'b0;
    #1;
    check_eq("mr_count", b2.count, 0);
    check_eq("mr_empty", b2.empty, 1);
    check_eq("mr_rdata", b2.r_data, 8'h00);
`ifdef RATIO_FIFO_ERR_EN
    check_eq("mr_ovf", ovf2, 0);
`endif
    #1 reset_n = 1'b1;

    // Simultaneous write and read at count 2
    wr2(16'hBBAA);
    b2.wr = 1'b1; b2.rd = 1'b1; b2.w_data = 16'hDDCC;
    cycle();
    b2.wr = 1'b0; b2.rd = 1'b0;
    check_eq("s_count3", b2.count, 3);
    check_eq("s_headBB", b2.r_data, 8'hBB);
    rd2();
    check_eq("s_headCC", b2.r_data, 8'hCC);
    rd2();
    check_eq("s_headDD", b2.r_data, 8'hDD);
    rd2();
    check_eq("s_empty", b2.empty, 1);

    // Read on empty is ignored
    rd2();
    check_eq("u_count", b2.count, 0);
    check_eq("u_empty", b2.empty, 1);
`ifdef RATIO_FIFO_ERR_EN
    check_eq("u_udf", udf2, 1);
`endif

    // Mixed traffic against a queue model; exercises pointer wrap and full rejection
    for (int i = 0; i < 40; i++) begin
      logic wr_ok, rd_ok;
      logic [15:0] d;
      b2.wr = ($urandom_range(0, 2) != 0);
      b2.rd = ($urandom_range(0, 1) != 0);
      d = 16'($urandom);
      b2.w_data = d;
      wr_ok = b2.wr && (q.size() <= 6);
      rd_ok = b2.rd && (q.size() != 0);
      cycle();
      if (rd_ok) void'(q.pop_front());
      if (wr_ok) begin
        q.push_back(d[7:0]);
        q.push_back(d[15:8]);
      end
      check_eq("wrap_count", b2.count, q.size());
      check_eq("wrap_rdata", b2.r_data, (q.size() != 0) ? q[0] : 8'h00);
      check_eq("wrap_full", b2.full, q.size() > 6);
      check_eq("wrap_empty", b2.empty, q.size() == 0);
    end
    b2.wr = 1'b0; b2.rd = 1'b0;

    // RATIO=4: single write then drain
    wr4(32'hDDCCBBAA);
    check_eq("r4_count4", b4.count, 4);
    check_eq("r4_full4", b4.full, 0);
    check_eq("r4_headAA", b4.r_data, 8'hAA);
    rd4();
    check_eq("r4_headBB", b4.r_data, 8'hBB);
    rd4();
    check_eq("r4_headCC", b4.r_data, 8'hCC);
    rd4();
    check_eq("r4_headDD", b4.r_data, 8'hDD);
    check_eq("r4_count1", b4.count, 1);
    rd4();
    check_eq("r4_empty", b4.empty, 1);
    check_eq("r4_rdata0", b4.r_data, 8'h00);

    // RATIO=4: fill, rejected write, full persists above DEPTH-RATIO
    wr4(32'h33221100);
    wr4(32'h77665544);
    check_eq("r4_count8", b4.count, 8);
    check_eq("r4_full", b4.full, 1);
    wr4(32'hBBAA9988);
    check_eq("r4_rej_count", b4.count, 8);
`ifdef RATIO_FIFO_ERR_EN
    check_eq("r4_ovf", ovf4, 1);
`endif
    rd4();
    check_eq("r4_count7", b4.count, 7);
    check_eq("r4_full7", b4.full, 1);
    check_eq("r4_head11", b4.r_data, 8'h11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
